// File: rtl/axi_lite_write_arbiter.sv
// rtl/axi_lite_write_arbiter.sv - two-requester round-robin arbiter issuing single AXI4-Lite writes
module axi_lite_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic [DATA_W/8-1:0] req0_strb,
  output logic                req0_ready,
  output logic                req0_done,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic [DATA_W/8-1:0] req1_strb,
  output logic                req1_ready,
  output logic                req1_done,
  output logic [1:0]          resp,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   gnt;
  logic   sel;
  logic   capture;
  logic   b_fire;
  logic   aw_pend;
  logic   w_pend;

  assign AWVALID = aw_pend;
  assign WVALID  = w_pend;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Ready is combinational so the grant pulse lands in the capture cycle itself.
  always_comb begin
    state_nxt  = state;
    sel        = 1'b0;
    capture    = 1'b0;
    b_fire     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    BREADY     = 1'b0;
    case (state)
      IDLE: begin
        if (!ARESET && (req0_valid || req1_valid)) begin
          sel        = (req0_valid && req1_valid) ? ptr : req1_valid;
          capture    = 1'b1;
          req0_ready = !sel;
          req1_ready = sel;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        if ((!aw_pend || AWREADY) && (!w_pend || WREADY)) state_nxt = RESP;
      end
      RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          b_fire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus registers are only reloaded on capture, which keeps them stable until RESP exits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      AWADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      resp      <= 2'b00;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (capture) begin
        gnt     <= sel;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
        AWADDR  <= sel ? req1_addr : req0_addr;
        WDATA   <= sel ? req1_data : req0_data;
        WSTRB   <= sel ? req1_strb : req0_strb;
      end else begin
        if (aw_pend && AWREADY) aw_pend <= 1'b0;
        if (w_pend && WREADY)   w_pend  <= 1'b0;
      end
      if (b_fire) begin
        resp      <= BRESP;
        req0_done <= !gnt;
        req1_done <= gnt;
        ptr       <= !gnt;
      end
    end
  end

endmodule
